// File: rtl/lane_word_bridge.sv
// lane_word_bridge: packs narrow pin lanes into RAM words and streams RAM words back out as lanes.
module lane_word_bridge #(
  parameter int WORD_W = 32,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_end,
  input  logic              in_valid,
  input  logic [LANE_W-1:0] in_data,
  output logic              in_ready,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] dump_addr,
  input  logic [ADDR_W-1:0] dump_count,
  output logic              out_valid,
  output logic [LANE_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);
  localparam int LANES = WORD_W / LANE_W;
  localparam int LW = $clog2(LANES);
  typedef enum logic [2:0] {IDLE, PACK, WRITE, RD, RDW, SHIFT} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] addr, rem;
  logic [LW-1:0] lane;
  logic [WORD_W-1:0] pack, shreg;
  logic in_acc, out_acc, lane_last;
  assign lane_last = lane == LW'(LANES - 1);
  assign in_acc = state == PACK && !load_end && in_valid;
  assign out_acc = state == SHIFT && out_ready;
  assign in_ready = state == PACK && !load_end;
  assign out_valid = state == SHIFT;
  assign out_data = state == SHIFT ? shreg[LANE_W-1:0] : '0;
  assign out_last = state == SHIFT && rem == '0 && lane_last;
  assign busy = state != IDLE;
  assign mem_we = state == WRITE;
  assign mem_addr = addr;
  assign mem_wdata = state == WRITE ? pack : '0;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = load_start ? PACK : dump_start ? RD : IDLE;
      PACK:    nxt = load_end ? IDLE : (in_acc && lane_last) ? WRITE : PACK;
      WRITE:   nxt = PACK;
      RD:      nxt = RDW;
      RDW:     nxt = SHIFT;
      SHIFT:   nxt = (out_acc && lane_last) ? (rem == '0 ? IDLE : RD) : SHIFT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      addr <= '0;
      rem <= '0;
      lane <= '0;
      pack <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            addr <= load_addr;
            lane <= '0;
          end else if (dump_start) begin
            addr <= dump_addr;
            rem <= dump_count;
            lane <= '0;
          end
        end
        PACK: begin
          if (load_end) lane <= '0;
          else if (in_acc) begin
            pack[lane*LANE_W +: LANE_W] <= in_data;
            lane <= lane_last ? '0 : lane + 1'b1;
          end
        end
        WRITE: addr <= addr + 1'b1;
        RDW: shreg <= mem_rdata;
        SHIFT: begin
          if (out_acc) begin
            shreg <= shreg >> LANE_W;
            lane <= lane_last ? '0 : lane + 1'b1;
            // Advance to the next word only when more words remain in the run.
            if (lane_last && rem != '0) begin
              rem <= rem - 1'b1;
              addr <= addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
